// File: rtl/rca_pkg.sv
// Shared constants and skew-register offset helpers for the pipelined ripple-carry adder.
package rca_pkg;
  localparam logic OP_ADD    = 1'b0;
  localparam logic OP_SUB    = 1'b1;
  localparam int   DEF_WIDTH = 16;
  localparam int   DEF_CHUNK = 4;

  // Operand skew after stage k keeps the WIDTH-(k+1)*CHUNK bits not yet added;
  // all stages are packed into one flat vector, this gives stage k's base.
  function automatic int opnd_off(input int width, input int chunk, input int k);
    int o;
    o = 0;
    for (int j = 0; j < k; j++) o += width - (j + 1) * chunk;
    return o;
  endfunction

  // Sum skew after stage k holds (k+1)*CHUNK finished bits.
  function automatic int sum_off(input int chunk, input int k);
    return chunk * k * (k + 1) / 2;
  endfunction
endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple adder; exposes the carry into its MSB for overflow.
module rca_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out,
  output logic             msb_carry_in
);
  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = c_in;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign c_out        = c[CHUNK];
  assign msb_carry_in = c[CHUNK-1];
endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry add/sub, one CHUNK per stage, skewed operands and sums.
// Define RCA_PIPE_OVF_EN to build the registered two's-complement overflow flag.
module rca_pipe
  import rca_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int OPW    = (STAGES > 1) ? opnd_off(WIDTH, CHUNK, STAGES - 1) : 1;
  localparam int SUMW   = sum_off(CHUNK, STAGES);

  logic [STAGES-1:0] vld_q, vld_d, vld_fwd;
  logic [STAGES-1:0] cy_q, cy_d, cy_fwd;
  logic [OPW-1:0]    a_sk_q, a_sk_d, a_fwd;
  logic [OPW-1:0]    b_sk_q, b_sk_d, b_fwd;
  logic [SUMW-1:0]   s_sk_q, s_sk_d, s_fwd;
  logic              adv, cin0;
  logic [WIDTH-1:0]  b_eff;

  assign adv      = !vld_q[STAGES-1] | out_ready;
  assign in_ready = adv;
  // SUB folds into ADD at the input: invert b and force the carry-in.
  assign b_eff    = (op == OP_SUB) ? ~b : b;
  assign cin0     = (op == OP_SUB) ? 1'b1 : c_in;

  if (STAGES == 1) begin : g_noskew
    assign a_fwd = '0;
    assign b_fwd = '0;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int AI  = (k > 0) ? opnd_off(WIDTH, CHUNK, k - 1) : 0;
    localparam int AO  = opnd_off(WIDTH, CHUNK, k);
    localparam int REM = WIDTH - (k + 1) * CHUNK;
    logic [CHUNK-1:0] ca, cb, cs;
    logic             ci, co, mci;

    if (k == 0) begin : g_first
      assign ca         = a[CHUNK-1:0];
      assign cb         = b_eff[CHUNK-1:0];
      assign ci         = cin0;
      assign vld_fwd[0] = in_valid;
      assign s_fwd[CHUNK-1:0] = cs;
    end else begin : g_next
      assign ca         = a_sk_q[AI +: CHUNK];
      assign cb         = b_sk_q[AI +: CHUNK];
      assign ci         = cy_q[k-1];
      assign vld_fwd[k] = vld_q[k-1];
      assign s_fwd[sum_off(CHUNK, k) +: (k+1)*CHUNK] =
        {cs, s_sk_q[sum_off(CHUNK, k-1) +: k*CHUNK]};
    end

    if (k < STAGES - 1) begin : g_skew
      if (k == 0) begin : g_skew_in
        assign a_fwd[0 +: REM] = a[CHUNK +: REM];
        assign b_fwd[0 +: REM] = b_eff[CHUNK +: REM];
      end else begin : g_skew_mid
        assign a_fwd[AO +: REM] = a_sk_q[AI + CHUNK +: REM];
        assign b_fwd[AO +: REM] = b_sk_q[AI + CHUNK +: REM];
      end
    end

    rca_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a            (ca),
      .b            (cb),
      .c_in         (ci),
      .sum          (cs),
      .c_out        (co),
      .msb_carry_in (mci)
    );

    assign cy_fwd[k] = co;
  end

  // Bubbles advance like real slots; only a stalled output freezes the pipe.
  always_comb begin
    vld_d  = vld_q;
    cy_d   = cy_q;
    a_sk_d = a_sk_q;
    b_sk_d = b_sk_q;
    s_sk_d = s_sk_q;
    if (adv) begin
      vld_d  = vld_fwd;
      cy_d   = cy_fwd;
      a_sk_d = a_fwd;
      b_sk_d = b_fwd;
      s_sk_d = s_fwd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      cy_q   <= '0;
      a_sk_q <= '0;
      b_sk_q <= '0;
      s_sk_q <= '0;
    end else begin
      vld_q  <= vld_d;
      cy_q   <= cy_d;
      a_sk_q <= a_sk_d;
      b_sk_q <= b_sk_d;
      s_sk_q <= s_sk_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = s_sk_q[sum_off(CHUNK, STAGES-1) +: WIDTH];
  assign c_out     = cy_q[STAGES-1];

`ifdef RCA_PIPE_OVF_EN
  logic ovf_q, ovf_d, ovf_fwd;

  assign ovf_fwd = g_stg[STAGES-1].mci ^ g_stg[STAGES-1].co;

  always_comb begin
    ovf_d = ovf_q;
    if (adv) ovf_d = ovf_fwd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_rca_pipe.sv
// Self-checking bench for rca_pipe (WIDTH=16, CHUNK=4): directed table, stall, reset and random streams.
module tb_rca_pipe;
  import rca_pkg::*;

  localparam int W = 16;
`ifdef RCA_PIPE_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         op = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rca_pipe #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, op;
    logic [W-1:0] s;
    logic         co, ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co, ov;
  } res_t;

  res_t exp_q[$];
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: integer arithmetic on the whole word, overflow from signed range.
  function automatic res_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                 input logic xc, input logic xop);
    res_t r;
    int   u, s;
    if (xop == OP_SUB) begin
      u = int'(xa) + 65536 - int'(xb);
      s = int'($signed(xa)) - int'($signed(xb));
    end else begin
      u = int'(xa) + int'(xb) + int'(xc);
      s = int'($signed(xa)) + int'($signed(xb)) + int'(xc);
    end
    r.s  = u[W-1:0];
    r.co = u[W];
    r.ov = OVF_ON & ((s > 32767) || (s < -32768));
    return r;
  endfunction

  task automatic run_single(input vec_t v, input string nm);
    @(negedge clk);
    a = v.a; b = v.b; c_in = v.cin; op = v.op; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk($sformatf("%s in_ready", nm), in_ready, 1);
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      in_valid = 1'b0; a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); op = 1'($urandom);
      #1;
      if (e < 4) chk($sformatf("%s early_valid@%0d", nm, e), out_valid, 0);
      else begin
        chk($sformatf("%s valid", nm), out_valid, 1);
        chk($sformatf("%s sum", nm), sum, v.s);
        chk($sformatf("%s c_out", nm), c_out, v.co);
        chk($sformatf("%s ovf", nm), ovf, v.ov & OVF_ON);
      end
    end
  endtask

  task automatic run_stream(input int n_txn, input bit stall_mode, input int max_cyc, input string nm);
    int           sent, got, cyc;
    bit           have;
    logic [W-1:0] ha, hb, hs;
    logic         hc, hop, hco, hov;
    res_t         e;
    sent = 0; got = 0; cyc = 0; have = 0;
    ha = '0; hb = '0; hc = 0; hop = 0; hs = '0; hco = 0; hov = 0;
    exp_q.delete();
    while (got < n_txn && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (!have && sent < n_txn && (stall_mode || $urandom_range(3) != 0)) begin
        ha = W'($urandom); hb = W'($urandom); hc = 1'($urandom); hop = 1'($urandom);
        have = 1;
      end
      in_valid = have; a = ha; b = hb; c_in = hc; op = hop;
      out_ready = stall_mode ? !(cyc >= 5 && cyc <= 7) : ($urandom_range(3) != 0);
      #1;
      if (stall_mode && cyc >= 5 && cyc <= 7) begin
        chk($sformatf("%s stall in_ready@%0d", nm, cyc), in_ready, 0);
        chk($sformatf("%s stall valid@%0d", nm, cyc), out_valid, 1);
        if (cyc == 5) begin
          hs = sum; hco = c_out; hov = ovf;
        end else begin
          chk($sformatf("%s stall sum@%0d", nm, cyc), sum, hs);
          chk($sformatf("%s stall c_out@%0d", nm, cyc), c_out, hco);
          chk($sformatf("%s stall ovf@%0d", nm, cyc), ovf, hov);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk($sformatf("%s unexpected_out", nm), 1, 0);
        else begin
          e = exp_q.pop_front();
          chk($sformatf("%s sum #%0d", nm, got), sum, e.s);
          chk($sformatf("%s c_out #%0d", nm, got), c_out, e.co);
          chk($sformatf("%s ovf #%0d", nm, got), ovf, e.ov);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(ha, hb, hc, hop));
        have = 0;
        sent++;
      end
    end
    chk($sformatf("%s delivered", nm), got, n_txn);
    chk($sformatf("%s leftover", nm), exp_q.size(), 0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, OP_ADD, 16'h2233, 1'b0, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, OP_ADD, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h0005, 16'h0007, 1'b0, OP_SUB, 16'hFFFE, 1'b0, 1'b0};
    tbl[3] = '{16'h0007, 16'h0005, 1'b0, OP_SUB, 16'h0002, 1'b1, 1'b0};
    tbl[4] = '{16'hFFFF, 16'h0000, 1'b1, OP_ADD, 16'h0000, 1'b1, 1'b0};
    tbl[5] = '{16'h8000, 16'h8000, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b1};
    tbl[6] = '{16'h8000, 16'h0001, 1'b0, OP_SUB, 16'h7FFF, 1'b1, 1'b1};
    tbl[7] = '{16'h0007, 16'h0005, 1'b1, OP_SUB, 16'h0002, 1'b1, 1'b0};

    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst sum", sum, 0);
    chk("rst c_out", c_out, 0);
    chk("rst ovf", ovf, 0);
    chk("rst in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post-rst in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) run_single(tbl[i], $sformatf("vec%0d", i));

    run_stream(8, 1'b1, 60, "stall");

    // Three in flight, the oldest sitting at the output when reset hits.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1; op = OP_ADD; c_in = 1'b0;
      a = W'(16'h0100 * (i + 1)); b = 16'h0011;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    #1 chk("inflight valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst sum", sum, 0);
    chk("midrst c_out", c_out, 0);
    chk("midrst in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1 chk("rel in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 chk($sformatf("stale valid@%0d", i), out_valid, 0);
    end
    run_single(tbl[0], "after_rst");

    run_stream(150, 1'b0, 3000, "random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rca_pipe.md
RCA_PIPE -- requirements
Module: rca_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits; SHALL be a multiple of CHUNK, minimum 4.
REQ-002 Parameter CHUNK, default 4: bits resolved per pipeline stage; STAGES = WIDTH/CHUNK.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1: operand set presented.
REQ-006 Port in_ready, output, 1: block accepts an operand set this cycle.
REQ-007 Port a, input, WIDTH: operand A.
REQ-008 Port b, input, WIDTH: operand B.
REQ-009 Port c_in, input, 1: carry-in; used in ADD mode only.
REQ-010 Port op, input, 1: 0 = ADD, 1 = SUB.
REQ-011 Port out_valid, output, 1: result present.
REQ-012 Port out_ready, input, 1: consumer accepts the result.
REQ-013 Port sum, output, WIDTH: result.
REQ-014 Port c_out, output, 1: carry out of the MSB; in SUB mode 1 = no borrow.
REQ-015 Port ovf, output, 1: two's-complement overflow flag.

Function
REQ-016 ADD: {c_out,sum} SHALL equal a + b + c_in, modulo 2^(WIDTH+1).
REQ-017 SUB: {c_out,sum} SHALL equal a + ~b + 1; c_in is ignored.
REQ-018 Stage k SHALL add operand bits [k*CHUNK +: CHUNK] with the registered carry from stage k-1; stage 0 uses c_in, or 1 in SUB mode.
REQ-019 Operand chunks above the active stage and sum chunks below it SHALL travel in skew registers with their transaction.
REQ-020 Latency SHALL be exactly STAGES cycles from an accepted input (in_valid & in_ready) to out_valid with its result.
REQ-021 Throughput SHALL be one transaction per cycle while out_ready is held high.
REQ-022 The whole pipeline SHALL advance when adv = !out_valid | out_ready; in_ready SHALL equal adv.
REQ-023 When adv = 0, every stage register SHALL hold, and sum/c_out/ovf SHALL stay stable while out_valid is high.
REQ-024 Bubbles (cycles with in_valid = 0) SHALL propagate as invalid slots and SHALL not be collapsed.
REQ-025 in_valid with in_ready = 0 SHALL not be captured; the producer must hold its data.
REQ-026 Wrap-around: with a = all-ones, b = 0, c_in = 1, ADD SHALL give sum = 0 and c_out = 1.
REQ-027 Simultaneous output consume and input accept in one cycle SHALL lose no transaction.

Reset
REQ-028 While rst_n = 0, all valid bits SHALL be 0, and sum, c_out, ovf and all data/carry registers SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight transactions, with no partial result emitted.
REQ-030 in_ready SHALL be 1 during reset and on the first cycle after release.

Configuration
REQ-031 With macro RCA_PIPE_OVF_EN defined, ovf SHALL equal the carry into the MSB XOR the carry out of the MSB, registered with its transaction.
REQ-032 Without RCA_PIPE_OVF_EN, ovf SHALL be constant 0 and no overflow logic or registers SHALL exist.

Structure
REQ-033 Package rca_pkg SHALL hold the op encoding constants OP_ADD = 1'b0 and OP_SUB = 1'b1, and default WIDTH/CHUNK localparams.
REQ-034 Sub-module rca_chunk SHALL be a combinational CHUNK-bit ripple adder (a, b, c_in -> sum, c_out, msb_carry_in), instantiated once per stage via generate.

Verification (WIDTH=16, CHUNK=4, latency 4)
REQ-035 Bench SHALL cover: a=16'h1234, b=16'h0FFF, c_in=0, ADD -> after 4 cycles sum=16'h2233, c_out=0, ovf=0.
REQ-036 Bench SHALL cover: a=16'h7FFF, b=16'h0001, ADD, c_in=0 -> sum=16'h8000, c_out=0, ovf=1 with the macro and 0 without.
REQ-037 Bench SHALL cover: a=16'h0005, b=16'h0007, SUB -> sum=16'hFFFE, c_out=0; a=16'h0007, b=16'h0005, SUB -> sum=16'h0002, c_out=1.
REQ-038 Bench SHALL cover: 8 back-to-back transactions with out_ready low for cycles 5-7 -> outputs held stable, in_ready=0 during the stall, all 8 results delivered in order with none lost.
REQ-039 Bench SHALL cover: rst_n pulsed low while 3 transactions are in flight -> out_valid=0 immediately, no stale result after release, and the next transaction has latency 4.
